trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl_if.sv | 28 ++
 rtl/trap_ctrl.sv | 121 ++++++++++++
 tb/tb_trap_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_if.sv
// Core-side bundle for the trap controller: boundary/CSR inputs and trap/redirect outputs.
interface trap_ctrl_if #(
    parameter int unsigned NIRQ = 4
) ();
    logic [NIRQ-1:0] irq_i;
    logic            interrupt_enable_i;
    logic [31:0]     epc_i;
    logic            instr_valid_i;
    logic [31:0]     pc_i;
    logic            mret_i;
    logic            save_epc_o;
    logic [31:0]     epc_pc_o;
    logic [4:0]      cause_o;
    logic [NIRQ-1:0] irq_ack_o;
    logic            redirect_o;
    logic [31:0]     redirect_pc_o;
    logic            stall_o;

    modport master (
        output irq_i, interrupt_enable_i, epc_i, instr_valid_i, pc_i, mret_i,
        input  save_epc_o, epc_pc_o, cause_o, irq_ack_o, redirect_o, redirect_pc_o, stall_o
    );

    modport slave (
        input  irq_i, interrupt_enable_i, epc_i, instr_valid_i, pc_i, mret_i,
        output save_epc_o, epc_pc_o, cause_o, irq_ack_o, redirect_o, redirect_pc_o, stall_o
    );
endinterface

// File: rtl/trap_ctrl.sv
// Interrupt entry / MRET sequencer: latches level IRQs, takes them at instruction
// boundaries, and pulses the mepc save and fetch redirect from registered state.
module trap_ctrl #(
    parameter int unsigned NIRQ        = 4,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0010
) (
    input  logic        clk,
    input  logic        rst_n,
    trap_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StSave, StVector, StMret} state_e;

    state_e          state_q, state_d;
    logic [NIRQ-1:0] pending_q, pending_d;
    logic [31:0]     addr_q, addr_d;
    logic [4:0]      cause_q, cause_d;
    logic [4:0]      lowest_idx;
    logic [NIRQ-1:0] ack_mask;
    logic            take_mret, take_irq;

    logic            save_epc;
    logic [31:0]     epc_pc;
    logic [4:0]      cause;
    logic [NIRQ-1:0] irq_ack;
    logic            redirect;
    logic [31:0]     redirect_pc;
    logic            stall;

    always_comb begin
        lowest_idx = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (pending_q[i]) lowest_idx = i[4:0];
        end
    end

    always_comb begin
        for (int i = 0; i < NIRQ; i++) begin
            ack_mask[i] = (state_q == StSave) && (cause_q == i[4:0]);
        end
    end

    // Level semantics: a still-asserted source re-pends in the same update that acks it.
    assign pending_d = (pending_q & ~ack_mask) | bus.irq_i;

    assign take_mret = (state_q == StIdle) && bus.instr_valid_i && bus.mret_i;
    assign take_irq  = (state_q == StIdle) && bus.instr_valid_i && !bus.mret_i &&
                       bus.interrupt_enable_i && (|pending_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pending_q <= '0;
            addr_q    <= '0;
            cause_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            addr_q    <= addr_d;
            cause_q   <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cause_d = cause_q;
        unique case (state_q)
            StIdle: begin
                if (take_mret) begin
                    state_d = StMret;
                    addr_d  = bus.epc_i;
                end else if (take_irq) begin
                    state_d = StSave;
                    addr_d  = bus.pc_i;
                    cause_d = lowest_idx;
                end
            end
            StSave:   state_d = StVector;
            StVector: state_d = StIdle;
            StMret:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        save_epc    = 1'b0;
        epc_pc      = '0;
        cause       = '0;
        irq_ack     = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        stall       = (state_q != StIdle);
        unique case (state_q)
            StSave: begin
                save_epc = 1'b1;
                epc_pc   = addr_q;
                cause    = cause_q;
                irq_ack  = ack_mask;
            end
            StVector: begin
                redirect    = 1'b1;
                redirect_pc = TRAP_VECTOR;
            end
            StMret: begin
                redirect    = 1'b1;
                redirect_pc = addr_q;
            end
            default: ;
        endcase
    end

    assign bus.save_epc_o    = save_epc;
    assign bus.epc_pc_o      = epc_pc;
    assign bus.cause_o       = cause;
    assign bus.irq_ack_o     = irq_ack;
    assign bus.redirect_o    = redirect;
    assign bus.redirect_pc_o = redirect_pc;
    assign bus.stall_o       = stall;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: a cycle-stamped event model feeds expected save/redirect
// pulses into queues; a negedge monitor compares every cycle.
module tb_trap_ctrl;
    localparam int unsigned NIRQ = 4;
    localparam logic [31:0] TV   = 32'h0000_0010;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    trap_ctrl_if #(.NIRQ(NIRQ)) bus ();

    trap_ctrl #(.NIRQ(NIRQ), .TRAP_VECTOR(TV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          stamp;
        logic [31:0] pc;
        logic [4:0]  cause;
    } save_t;

    typedef struct {
        int          stamp;
        logic [31:0] pc;
    } redir_t;

    save_t  save_q[$];
    redir_t redir_q[$];

    int total = 0;
    int bad   = 0;

    // Model state: cycle counter, pending set, cycle at which the controller is free again.
    int              cyc     = 0;
    int              free_at = 0;
    int              ack_at  = -1;
    int              ack_idx = 0;
    logic [NIRQ-1:0] pend    = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lowest(input logic [NIRQ-1:0] p);
        for (int i = 0; i < NIRQ; i++) if (p[i]) return i;
        return -1;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            pend    = '0;
            free_at = 0;
            ack_at  = -1;
            save_q.delete();
            redir_q.delete();
        end else begin
            if (cyc >= free_at && bus.instr_valid_i) begin
                if (bus.mret_i) begin
                    redir_t r;
                    r.stamp = cyc;
                    r.pc    = bus.epc_i;
                    redir_q.push_back(r);
                    free_at = cyc + 2;
                end else if (bus.interrupt_enable_i && pend != '0) begin
                    save_t  s;
                    redir_t r;
                    int     k;
                    k       = lowest(pend);
                    s.stamp = cyc;
                    s.pc    = bus.pc_i;
                    s.cause = 5'(k);
                    save_q.push_back(s);
                    r.stamp = cyc + 1;
                    r.pc    = TV;
                    redir_q.push_back(r);
                    free_at = cyc + 3;
                    ack_at  = cyc + 1;
                    ack_idx = k;
                end
            end
            if (ack_at == cyc) pend[ack_idx] = 1'b0;
            pend = pend | bus.irq_i;
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            logic            exp_save, exp_redir;
            logic [31:0]     exp_epc, exp_rpc;
            logic [4:0]      exp_cause;
            logic [NIRQ-1:0] exp_ack;
            logic [NIRQ-1:0] one;
            @(negedge clk);
            one       = 1;
            exp_save  = (save_q.size() > 0) && (save_q[0].stamp == cyc);
            exp_redir = (redir_q.size() > 0) && (redir_q[0].stamp == cyc);
            exp_epc   = '0;
            exp_cause = '0;
            exp_ack   = '0;
            exp_rpc   = '0;
            if (exp_save) begin
                save_t s;
                s         = save_q.pop_front();
                exp_epc   = s.pc;
                exp_cause = s.cause;
                exp_ack   = one << s.cause;
            end
            if (exp_redir) begin
                redir_t r;
                r       = redir_q.pop_front();
                exp_rpc = r.pc;
            end
            check("stall_o", 32'(bus.stall_o), 32'(cyc + 1 < free_at));
            check("save_epc_o", 32'(bus.save_epc_o), 32'(exp_save));
            check("epc_pc_o", bus.epc_pc_o, exp_epc);
            check("cause_o", 32'(bus.cause_o), 32'(exp_cause));
            check("irq_ack_o", 32'(bus.irq_ack_o), 32'(exp_ack));
            check("redirect_o", 32'(bus.redirect_o), 32'(exp_redir));
            check("redirect_pc_o", bus.redirect_pc_o, exp_rpc);
            check("save_and_redirect", 32'(bus.save_epc_o & bus.redirect_o), 32'(0));
        end
    end

    task automatic step(input logic v, input logic m, input logic mie,
                        input logic [NIRQ-1:0] irq, input logic [31:0] pc,
                        input logic [31:0] epc);
        bus.instr_valid_i      = v;
        bus.mret_i             = m;
        bus.interrupt_enable_i = mie;
        bus.irq_i              = irq;
        bus.pc_i               = pc;
        bus.epc_i              = epc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n, input logic mie);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, mie, '0, 32'h0, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        step(1'b0, 1'b0, 1'b0, '0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b0, '0, 32'h0, 32'h0);
        rst_n = 1'b1;
        idle_cycles(2, 1'b1);

        // Basic entry: cause 2 at pc 0x100, then vector.
        step(1'b1, 1'b0, 1'b1, 4'b0100, 32'h100, 32'h0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, '0, 32'h100, 32'h0);
        idle_cycles(2, 1'b1);

        // Priority: 1 before 3, with source 3 still held afterwards.
        step(1'b0, 1'b0, 1'b1, 4'b1010, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 4'b1010, 32'h204, 32'h0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1, 4'b1000, 32'h208, 32'h0);
        idle_cycles(3, 1'b1);

        // Masking: one-cycle pulse held in pending until MIE rises.
        step(1'b1, 1'b0, 1'b0, 4'b0001, 32'h300, 32'h0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, '0, 32'h300, 32'h0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, '0, 32'h304, 32'h0);
        idle_cycles(2, 1'b1);

        // MRET beats an eligible interrupt; interrupt follows at the next boundary.
        step(1'b0, 1'b0, 1'b1, 4'b0010, 32'h0, 32'h0);
        step(1'b1, 1'b1, 1'b1, '0, 32'h400, 32'h200);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, '0, 32'h404, 32'h0);
        idle_cycles(2, 1'b1);

        // Reset during SAVE aborts the sequence and clears pending.
        step(1'b0, 1'b0, 1'b1, 4'b0110, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b1, '0, 32'h500, 32'h0);
        rst_n = 1'b0;
        step(1'b1, 1'b0, 1'b1, '0, 32'h500, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, '0, 32'h504, 32'h0);

        // Randomised traffic, including occasional resets.
        for (int i = 0; i < 1500; i++) begin
            logic [NIRQ-1:0] irq;
            rst_n = ($urandom_range(0, 99) != 0);
            irq   = ($urandom_range(0, 3) == 0) ? NIRQ'($urandom) : '0;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 2) != 0, irq,
                 {$urandom, 2'b00} & 32'hFFFF_FFFC, {$urandom, 2'b00} & 32'hFFFF_FFFC);
        end
        rst_n = 1'b1;
        idle_cycles(4, 1'b0);

        check("save_queue_drained", 32'(save_q.size()), 32'(0));
        check("redirect_queue_drained", 32'(redir_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
